// File: rtl/am_lock_rx_if.sv
// am_lock_rx_if: 66b block stream into the AM lock stage and its registered outputs and flags
interface am_lock_rx_if #(parameter int BLOCK_W = 66);
  logic               valid_i;
  logic               block_lock_i;
  logic [BLOCK_W-1:0] data_i;
  logic               valid_o;
  logic [BLOCK_W-1:0] data_o;
  logic               am_lite_v_o;
  logic               am_lite_lock_v_o;
  logic               am_lite_lock_lost_v_o;
  logic [1:0]         lane_id_o;
  modport master (
    output valid_i, block_lock_i, data_i,
    input  valid_o, data_o, am_lite_v_o, am_lite_lock_v_o, am_lite_lock_lost_v_o, lane_id_o
  );
  modport slave (
    input  valid_i, block_lock_i, data_i,
    output valid_o, data_o, am_lite_v_o, am_lite_lock_v_o, am_lite_lock_lost_v_o, lane_id_o
  );
endinterface

// File: rtl/am_lock_rx.sv
// am_lock_rx: per-lane 40GBASE-R alignment-marker find/confirm/lock with lane identification.
// Define AM_BIP_CHECK_EN to additionally require BIP7 == ~BIP3 on every marker match.
module am_lock_rx #(
  parameter int BLOCK_W   = 66,
  parameter int AM_PERIOD = 16384,
  parameter int AM_INV_N  = 4,
  parameter int CNT_W     = $clog2(AM_PERIOD)
) (
  input logic         clk,
  input logic         reset,
  am_lock_rx_if.slave bus
);
  typedef enum logic [1:0] {FIND, WAIT2, LOCKED} state_t;
  localparam int INV_W = $clog2(AM_INV_N + 1);
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [INV_W-1:0]   inv, inv_n, inv_inc;
  logic [1:0]         lane, lane_n, hit_lane;
  logic [BLOCK_W-1:0] d;
  logic [47:0]        key;
  logic [3:0]         m;
  logic               bip_ok, exp_pos, own, am_n;
  assign d = bus.data_i;
  assign key = {d[55:32], d[23:0]};
`ifdef AM_BIP_CHECK_EN
  assign bip_ok = d[63:56] == ~d[31:24];
`else
  assign bip_ok = 1'b1;
`endif
  assign m = {4{d[65:64] == 2'b10 && bip_ok}} &
             {key == 48'hc2865d3d79a2, key == 48'h649a3a9b65c5,
              key == 48'h193b0fe6c4f0, key == 48'hb8896f477690};
  assign hit_lane = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  assign own = m[lane];
  assign exp_pos = cnt == CNT_W'(AM_PERIOD - 1);
  assign inv_inc = inv + 1'b1;
  assign bus.lane_id_o = lane;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    inv_n   = inv;
    lane_n  = lane;
    am_n    = 1'b0;
    if (!bus.block_lock_i) begin
      state_n = FIND;
      inv_n   = '0;
    end else if (bus.valid_i) begin
      cnt_n = exp_pos ? '0 : cnt + 1'b1;
      case (state)
        FIND: if (|m) begin
          lane_n  = hit_lane;
          cnt_n   = '0;
          am_n    = 1'b1;
          state_n = WAIT2;
        end
        WAIT2: if (exp_pos) begin
          state_n = own ? LOCKED : FIND;
          am_n    = own;
          inv_n   = '0;
        end
        LOCKED: if (exp_pos) begin
          am_n    = own;
          inv_n   = own || inv_inc == INV_W'(AM_INV_N) ? '0 : inv_inc;
          state_n = !own && inv_inc == INV_W'(AM_INV_N) ? FIND : LOCKED;
        end
        default: state_n = FIND;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                     <= FIND;
      cnt                       <= '0;
      inv                       <= '0;
      lane                      <= '0;
      bus.valid_o               <= 1'b0;
      bus.data_o                <= '0;
      bus.am_lite_v_o           <= 1'b0;
      bus.am_lite_lock_v_o      <= 1'b0;
      bus.am_lite_lock_lost_v_o <= 1'b0;
    end else begin
      state                     <= state_n;
      cnt                       <= cnt_n;
      inv                       <= inv_n;
      lane                      <= lane_n;
      bus.valid_o               <= bus.valid_i;
      bus.data_o                <= d;
      bus.am_lite_v_o           <= am_n;
      bus.am_lite_lock_v_o      <= state_n == LOCKED;
      bus.am_lite_lock_lost_v_o <= state == LOCKED && state_n != LOCKED;
    end
  end
endmodule

// File: tb/tb_am_lock_rx.sv
// tb_am_lock_rx: directed checks of AM find, confirm, lock loss, valid gaps and block-lock drop.
module tb_am_lock_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  am_lock_rx_if #(.BLOCK_W(66)) bus ();
  am_lock_rx #(.AM_PERIOD(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [65:0] am(input int l, input logic [7:0] b3, input logic [7:0] b7);
    logic [47:0] k;
    k = l == 0 ? 48'hb8896f477690 : l == 1 ? 48'h193b0fe6c4f0 :
        l == 2 ? 48'h649a3a9b65c5 : 48'hc2865d3d79a2;
    return {2'b10, b7, k[47:24], b3, k[23:0]};
  endfunction
  function automatic logic [65:0] rnd();
    return {2'b01, 32'($urandom), 32'($urandom)};
  endfunction
  task automatic step(input string tag, input logic v, input logic bl, input logic [65:0] blk,
                      input logic e_am, input logic e_lock, input logic e_lost);
    bus.valid_i = v;
    bus.block_lock_i = bl;
    bus.data_i = blk;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 66'(bus.valid_o), 66'(v));
    check({tag, ".am"}, 66'(bus.am_lite_v_o), 66'(e_am));
    check({tag, ".lock"}, 66'(bus.am_lite_lock_v_o), 66'(e_lock));
    check({tag, ".lost"}, 66'(bus.am_lite_lock_lost_v_o), 66'(e_lost));
  endtask
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 66'(bus.valid_o), 66'(0));
    check({tag, ".rst_am"}, 66'(bus.am_lite_v_o), 66'(0));
    check({tag, ".rst_lock"}, 66'(bus.am_lite_lock_v_o), 66'(0));
    check({tag, ".rst_lost"}, 66'(bus.am_lite_lock_lost_v_o), 66'(0));
    check({tag, ".rst_lane"}, 66'(bus.lane_id_o), 66'(0));
    check({tag, ".rst_data"}, bus.data_o, 66'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [65:0] b;
    bit bad;
    bus.valid_i = 1'b0;
    bus.block_lock_i = 1'b1;
    bus.data_i = '0;
    do_reset("init");
    for (int i = 0; i < 12; i++) begin
      b = (i == 3 || i == 11) ? am(2, 8'h5a, 8'ha5) : rnd();
      step($sformatf("lock%0d", i), 1, 1, b, i == 3 || i == 11, i >= 11, 0);
    end
    check("lock.lane", 66'(bus.lane_id_o), 66'(2));
    check("lock.data", bus.data_o, am(2, 8'h5a, 8'ha5));
    do_reset("midlock");
    for (int i = 0; i < 17; i++) begin
      b = (i == 0 || i == 16) ? am(1, 8'h5a, 8'ha5) : i == 8 ? am(3, 8'h5a, 8'ha5) : rnd();
      step($sformatf("wrong%0d", i), 1, 1, b, i == 0 || i == 16, 0, 0);
    end
    check("wrong.lane", 66'(bus.lane_id_o), 66'(1));
    do_reset("loss");
    for (int i = 0; i <= 80; i++) begin
      bad = i inside {16, 24, 32, 48, 56, 64, 72};
      b = (i % 8 == 0 && !bad) ? am(0, 8'h5a, 8'ha5) : rnd();
      step($sformatf("loss%0d", i), 1, 1, b, i % 8 == 0 && !bad, i >= 8 && i < 72, i == 72);
    end
    do_reset("gap");
    for (int i = 0; i <= 8; i++) begin
      b = (i % 8 == 0) ? am(0, 8'h5a, 8'ha5) : rnd();
      step($sformatf("gaplock%0d", i), 1, 1, b, i % 8 == 0, i >= 8, 0);
    end
    for (int p = 0; p < 3; p++)
      for (int k = 1; k <= 8; k++) begin
        for (int g = 0; g <= k % 5; g++)
          step($sformatf("bubble%0d_%0d", p, k), 0, 1, am(0, 8'h5a, 8'ha5), 0, 1, 0);
        step($sformatf("gap%0d_%0d", p, k), 1, 1, k == 8 ? am(0, 8'h5a, 8'ha5) : rnd(), k == 8, 1, 0);
      end
    step("bldrop", 1, 0, am(0, 8'h5a, 8'ha5), 0, 0, 1);
    step("blafter", 1, 1, rnd(), 0, 0, 0);
    do_reset("bip");
    step("bip_ok", 1, 1, am(0, 8'h5a, 8'ha5), 1, 0, 0);
    do_reset("bip2");
`ifdef AM_BIP_CHECK_EN
    step("bip_bad", 1, 1, am(0, 8'h5a, 8'h00), 0, 0, 0);
`else
    step("bip_bad", 1, 1, am(0, 8'h5a, 8'h00), 1, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/am_lock_rx.md
Name: am_lock_rx

Overview:
- Per-lane 40GBASE-R alignment-marker (AM) lock stage: one instance per physical lane, between the block-sync/descrambler-bypass stage and deskew_rx.
- Finds the lane's AM in a stream of 66-bit blocks and confirms it at the fixed AM period.
- Tracks lock and reports lane identity.
- Produces the am_lite_v / am_lite_lock_v / am_lite_lock_lost_v signals consumed by deskew_rx.

Parameters:
- BLOCK_W, 66, block width incl. 2-bit sync header.
- AM_PERIOD, 16384, valid blocks from one AM to the next (AM inclusive); sims use 8.
- AM_INV_N, 4, consecutive mismatches at expected positions before lock is lost.
- CNT_W, $clog2(AM_PERIOD), period counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  data_i holds a valid block this cycle.
- block_lock_i  in  1  upstream 66b block lock; low forces unlock.
- data_i  in  BLOCK_W  received block; [65:64] sync header, [63:0] payload.
- valid_o  out  1  registered valid_i.
- data_o  out  BLOCK_W  registered data_i.
- am_lite_v_o  out  1  data_o is a matched AM of this lane.
- am_lite_lock_v_o  out  1  AM lock held (level).
- am_lite_lock_lost_v_o  out  1  one-cycle pulse on lock loss.
- lane_id_o  out  2  logical lane identified by the first matched AM; valid while am_lite_lock_v_o=1.

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-high.
- Reset: all outputs 0, FSM=FIND, counters 0.
- Latency: 1 cycle. data_o/valid_o/flags are registered together, so every flag refers to the block currently on data_o.
- AM match ("lite"):
  - Requires header [65:64]=2'b10.
  - Bits [63:56] (BIP7) and [31:24] (BIP3) are ignored.
  - Remaining bytes [55:48],[47:40],[39:32],[23:16],[15:8],[7:0] must equal one of:
    - L0 b8,89,6f,47,76,90
    - L1 19,3b,0f,e6,c4,f0
    - L2 64,9a,3a,9b,65,c5
    - L3 c2,86,5d,3d,79,a2
  - Only evaluated when valid_i=1.
- Period counter:
  - Advances only on valid_i=1.
  - Loads 0 on the block where an AM is accepted; wraps at AM_PERIOD-1.
  - The expected-AM position is the valid block with cnt==AM_PERIOD-1 before the increment.
- FSM:
  - FIND:
    - Compare every valid block against all 4 AMs.
    - On a match: latch lane_id, cnt<=0, am_lite_v_o=1 for that block, go WAIT2.
  - WAIT2:
    - At the expected position, a match with the latched lane_id -> LOCKED; am_lite_v_o=1 for that block; am_lite_lock_v_o rises on the same output cycle.
    - Anything else at that position (no match, or a different lane) -> FIND; that block is not re-evaluated as a first AM.
    - Non-expected positions are ignored.
  - LOCKED:
    - At the expected position, compare only against the latched lane.
    - Match: inv_cnt<=0, am_lite_v_o=1.
    - Mismatch: inv_cnt++. When inv_cnt reaches AM_INV_N: lock_v falls, lock_lost pulses 1 cycle, go FIND.
    - Non-expected blocks are never flagged, even if they match.
- block_lock_i=0 (any state, checked each cycle regardless of valid_i):
  - Go FIND.
  - If leaving LOCKED, pulse am_lite_lock_lost_v_o and drop lock_v on the same output cycle.
  - No AM is evaluated while block_lock_i=0.
- valid_i=0: counter and FSM frozen; valid_o=0; am_lite_v_o=0.
- Simultaneous mismatch-triggered loss and block_lock_i drop produce a single lost pulse.
- Reset asserted mid-lock: outputs clear asynchronously with no lost pulse.

Optional Feature:
- Macro AM_BIP_CHECK_EN.
- Defined: an AM match additionally requires data_i[63:56] == ~data_i[31:24] (BIP7 is the complement of BIP3). This applies to both FIND and expected-position checks.
- Undefined: BIP bytes are ignored entirely (lite match).

Test Plan:
- Lock: AM_PERIOD=8, reset, block_lock_i=1. Random blocks, then L2 marker at block 3, random, L2 at block 11 -> am_lite_v_o pulses at both markers (1 cycle late), lane_id_o=2, am_lite_lock_v_o=1 from the second marker onward.
- Wrong confirm: L1 at block 0, L3 at block 8 -> no lock, FSM back to FIND; L1 at block 16 is treated as a new first AM (am_lite_v_o=1, lock_v still 0).
- Lock loss: locked on L0; corrupt 4 consecutive expected AMs -> lock_lost pulses exactly once on the 4th, lock_v=0. With 3 corruptions then a good AM -> lock held, inv_cnt cleared.
- Valid gaps: while locked, insert valid_i=0 bubbles of 1 to 5 cycles -> marker still detected at the 8th valid block; no lock loss.
- block_lock_i drop: while locked, pull block_lock_i low 1 cycle -> one lost pulse, lock_v=0. Mid-lock reset -> all outputs 0, no pulse.
- AM_BIP_CHECK_EN: L0 marker with BIP3=8'h5a, BIP7=8'ha5 -> match. With BIP7=8'h00 -> match only when the macro is undefined.
